// File: rtl/result_writeback_pkg.sv
// Shared types, default widths and lane helpers for the result write-back block.
package result_writeback_pkg;

    localparam int DEF_PARTIAL_SUM_BW = 20;
    localparam int DEF_MATRIX_SIZE    = 8;
    localparam int DEF_ADDRESSSIZE    = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } wb_state_e;

    // Bit offset of the LSB of lane 'lane' in a packed vector of 'bw'-bit lanes.
    function automatic int lane_lo(input int lane, input int bw);
        return lane * bw;
    endfunction

endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry FIFO between the vector multiplier and the result SRAM write port.
module result_skid_fifo #(
    parameter int WIDTH = 160
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign head_data = mem_q[rd_ptr_q];
    assign do_pop    = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/result_writeback.sv
// Collects one tile of result vectors and streams them into the result SRAM.
// Optional lane clamp to zero enabled by RESULT_WRITEBACK_RELU_EN.
module result_writeback
    import result_writeback_pkg::*;
#(
    parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter int ADDRESSSIZE    = DEF_ADDRESSSIZE,
    parameter int TILE_ROWS      = 8
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic [ADDRESSSIZE-1:0]              base_addr,
    input  logic                                in_valid,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
    output logic                                in_ready,
    input  logic                                wr_ready,
    output logic                                wr_en,
    output logic [ADDRESSSIZE-1:0]              wr_addr,
    output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] wr_data,
    output logic                                busy,
    output logic                                done,
    output logic                                drop_err
);

    localparam int VW = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam int CW = $clog2(TILE_ROWS + 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(TILE_ROWS - 1);

    wb_state_e              state_q;
    logic [CW-1:0]          row_cnt_q;
    logic [CW-1:0]          wr_cnt_q;
    logic [ADDRESSSIZE-1:0] addr_q;
    logic                   drop_err_q;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic [VW-1:0]          push_data;

`ifdef RESULT_WRITEBACK_RELU_EN
    for (genvar g = 0; g < MATRIX_SIZE; g++) begin : g_relu
        localparam int LO = lane_lo(g, PARTIAL_SUM_BW);
        assign push_data[LO +: PARTIAL_SUM_BW] =
            in_data[LO + PARTIAL_SUM_BW - 1] ? '0 : in_data[LO +: PARTIAL_SUM_BW];
    end
`else
    assign push_data = in_data;
`endif

    // in_ready depends only on registered state and occupancy, never on wr_ready.
    assign in_ready = (state_q == ST_COLLECT) && !fifo_full;
    assign push     = in_valid && in_ready;
    assign wr_en    = !fifo_empty;
    assign pop      = wr_en && wr_ready;
    assign wr_addr  = addr_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DRAIN) && pop && (wr_cnt_q == LAST_ROW);
    assign drop_err = drop_err_q;

    result_skid_fifo #(
        .WIDTH (VW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rstn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (wr_data)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q    <= ST_IDLE;
            row_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            addr_q     <= '0;
            drop_err_q <= 1'b0;
        end else begin
            if (pop) begin
                addr_q   <= addr_q + 1'b1;
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_COLLECT;
                        addr_q     <= base_addr;
                        row_cnt_q  <= '0;
                        wr_cnt_q   <= '0;
                        drop_err_q <= 1'b0;
                    end else if (in_valid) begin
                        drop_err_q <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (push) begin
                        if (row_cnt_q == LAST_ROW) begin
                            state_q   <= ST_DRAIN;
                            row_cnt_q <= '0;
                        end else begin
                            row_cnt_q <= row_cnt_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (done) begin
                        state_q  <= ST_IDLE;
                        wr_cnt_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: cycle table for streaming plus tile-level sequences.
module tb_result_writeback;

    logic         clk;
    logic         rstn;
    logic         start;
    logic [9:0]   base_addr;
    logic         in_valid;
    logic [159:0] in_data;
    logic         in_ready;
    logic         wr_ready;
    logic         wr_en;
    logic [9:0]   wr_addr;
    logic [159:0] wr_data;
    logic         busy;
    logic         done;
    logic         drop_err;

    int checks = 0;
    int errors = 0;
    bit relu_mode = 0;

    result_writeback #(
        .PARTIAL_SUM_BW (20),
        .MATRIX_SIZE    (8),
        .ADDRESSSIZE    (10),
        .TILE_ROWS      (8)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_ready  (wr_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [9:0] base;
        logic       vld;
        int         didx;
        logic       wrr;
        logic       e_rdy;
        logic       e_wen;
        logic [9:0] e_addr;
        int         e_didx;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [159:0] vec(input int k);
        logic [159:0] v;
        v = '0;
        if (relu_mode && k == 0) begin
            v[19:0]  = 20'd7;
            v[79:60] = 20'hFFFFB;
        end else begin
            for (int l = 0; l < 8; l++) v[l*20 +: 20] = 20'(k * 16 + l + 1);
        end
        return v;
    endfunction

    function automatic logic [159:0] exp_vec(input int k);
        logic [159:0] v;
        v = vec(k);
`ifdef RESULT_WRITEBACK_RELU_EN
        if (relu_mode && k == 0) v[79:60] = 20'h00000;
`endif
        return v;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic run_tile(input logic [9:0] base, input int stall_from, input int stall_len,
                            input int stray_cyc, input bit chk_lat);
        int sent, got, cyc, last_push, done_cyc;
        bit prev_hold, done_seen, exp_rdy, acc;
        logic [9:0]   h_addr, ea;
        logic [159:0] h_data;
        @(negedge clk);
        start = 1'b1; base_addr = base; in_valid = 1'b0; wr_ready = 1'b1;
        @(negedge clk);
        sent = 0; got = 0; cyc = 0; last_push = -1; done_cyc = -1;
        prev_hold = 0; done_seen = 0; h_addr = '0; h_data = '0;
        while (!done_seen && cyc < 40) begin
            in_valid  = (sent < 8);
            in_data   = vec(sent);
            wr_ready  = !(cyc >= stall_from && cyc < stall_from + stall_len);
            start     = (cyc == stray_cyc);
            base_addr = start ? 10'h155 : base;
            #1;
            exp_rdy = (sent < 8) && (sent - got < 2);
            chk("in_ready", in_ready, exp_rdy);
            chk("wr_en", wr_en, (sent - got) > 0);
            chk("busy", busy, 1'b1);
            chk("drop_err", drop_err, 1'b0);
            if (wr_en && prev_hold) begin
                chk("hold_addr", wr_addr, h_addr);
                chk("hold_data", wr_data, h_data);
            end
            prev_hold = wr_en && !wr_ready;
            h_addr = wr_addr;
            h_data = wr_data;
            acc = wr_en && wr_ready;
            if (acc) begin
                ea = base + 10'(got);
                chk("wr_addr", wr_addr, ea);
                chk("wr_data", wr_data, exp_vec(got));
                got++;
            end
            chk("done", done, acc && got == 8);
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
            if (in_valid && exp_rdy) begin
                sent++;
                last_push = cyc;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
        chk("done_seen", done_seen, 1'b1);
        chk("writes", got, 8);
        #1;
        chk("busy_after", busy, 1'b0);
        chk("wr_en_after", wr_en, 1'b0);
        if (chk_lat) chk("done_latency", done_cyc, last_push + 1);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 10'h010, 1'b0, 0, 1'b1, 1'b0, 1'b0, 10'h000, -1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 10'h010, 1'b1, 0, 1'b1, 1'b1, 1'b0, 10'h010, -1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 10'h010, 1'b1, 1, 1'b1, 1'b1, 1'b1, 10'h010,  0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 10'h010, 1'b1, 2, 1'b1, 1'b1, 1'b1, 10'h011,  1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 10'h010, 1'b1, 3, 1'b1, 1'b1, 1'b1, 10'h012,  2, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 10'h010, 1'b1, 4, 1'b1, 1'b1, 1'b1, 10'h013,  3, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 10'h010, 1'b1, 5, 1'b1, 1'b1, 1'b1, 10'h014,  4, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 10'h010, 1'b1, 6, 1'b1, 1'b1, 1'b1, 10'h015,  5, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 10'h010, 1'b1, 7, 1'b1, 1'b1, 1'b1, 10'h016,  6, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 10'h010, 1'b0, 0, 1'b1, 1'b0, 1'b1, 10'h017,  7, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 10'h010, 1'b0, 0, 1'b1, 1'b0, 1'b0, 10'h018, -1, 1'b0, 1'b0};

        rstn = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_data = '0; wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 10'h000);
        chk("rst_wr_data", wr_data, 160'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_drop_err", drop_err, 1'b0);

        // Streaming tile, one cycle per table row.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            start     = tbl[i].start;
            base_addr = tbl[i].base;
            in_valid  = tbl[i].vld;
            in_data   = vec(tbl[i].didx);
            wr_ready  = tbl[i].wrr;
            #1;
            chk($sformatf("stream%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            chk($sformatf("stream%0d_wr_en", i), wr_en, tbl[i].e_wen);
            chk($sformatf("stream%0d_wr_addr", i), wr_addr, tbl[i].e_addr);
            chk($sformatf("stream%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("stream%0d_done", i), done, tbl[i].e_done);
            if (tbl[i].e_didx >= 0)
                chk($sformatf("stream%0d_wr_data", i), wr_data, exp_vec(tbl[i].e_didx));
        end
        start = 1'b0; in_valid = 1'b0;

        // Vector while idle is dropped and flagged.
        @(negedge clk);
        in_valid = 1'b1; in_data = vec(0);
        #1;
        chk("idle_in_ready", in_ready, 1'b0);
        chk("idle_wr_en", wr_en, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("drop_err_set", drop_err, 1'b1);
        chk("drop_wr_en", wr_en, 1'b0);
        chk("drop_busy", busy, 1'b0);

        // Start clears drop_err; a stray start mid-tile must not move the address.
        run_tile(10'h040, 100, 0, 2, 1'b1);

        // Backpressure mid-tile.
        run_tile(10'h100, 3, 5, -1, 1'b0);

        // Address wrap.
        run_tile(10'h3FE, 100, 0, -1, 1'b1);

        // Negative lane handling.
        relu_mode = 1;
        run_tile(10'h020, 100, 0, -1, 1'b1);
        relu_mode = 0;

        // Reset mid-tile after 4 vectors.
        @(negedge clk);
        start = 1'b1; base_addr = 10'h080;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = vec(k); wr_ready = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rstn = 1'b1;
        #1;
        chk("midrst_done_during", done, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_wr_en", wr_en, 1'b0);
        chk("midrst_wr_addr", wr_addr, 10'h000);
        chk("midrst_wr_data", wr_data, 160'h0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_drop_err", drop_err, 1'b0);
        @(negedge clk);
        #1;
        chk("midrst_no_write", wr_en, 1'b0);
        chk("midrst_no_done", done, 1'b0);
        run_tile(10'h080, 100, 0, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_writeback.md
RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 Parameters SHALL be: PARTIAL_SUM_BW, default 20, lane width; MATRIX_SIZE, default 8, lanes per result vector; ADDRESSSIZE, default 10, result-SRAM address width; TILE_ROWS, default 8, result vectors per tile.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock; all logic on the rising edge.
- rstn  in  1  synchronous, active-high reset; asserted = 1.
- start  in  1  one-cycle pulse that arms a tile.
- base_addr  in  ADDRESSSIZE  first result-SRAM address, sampled on an accepted start.
- in_valid  in  1  result vector from the vector multiplier is present.
- in_data  in  PARTIAL_SUM_BW*MATRIX_SIZE  signed lanes; lane 0 in the LSBs.
- in_ready  out  1  block can accept a vector.
- wr_ready  in  1  result SRAM can take a write this cycle.
- wr_en  out  1  result-SRAM write strobe.
- wr_addr  out  ADDRESSSIZE  write address.
- wr_data  out  PARTIAL_SUM_BW*MATRIX_SIZE  write data.
- busy  out  1  tile in progress.
- done  out  1  one-cycle pulse when the tile's last write is accepted.
- drop_err  out  1  sticky: a vector arrived while IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, COLLECT and DRAIN.
- IDLE -> COLLECT on start.
- COLLECT -> DRAIN when the TILE_ROWS-th vector is accepted.
- DRAIN -> IDLE when the FIFO is empty and the last write is accepted; done pulses in that same cycle.
REQ-004 An input transfer SHALL occur when in_valid && in_ready; in_ready SHALL be 1 only in COLLECT with the FIFO not full.
REQ-005 Accepted vectors SHALL go into a 2-entry FIFO.
- Simultaneous push and pop on a full FIFO is allowed.
- in_ready SHALL be computed from registered occupancy only (no combinational path from wr_ready).
REQ-006 wr_en SHALL equal FIFO-not-empty.
- wr_data and wr_addr SHALL hold steady while wr_en && !wr_ready.
- A write is accepted when wr_en && wr_ready.
REQ-007 wr_addr SHALL start at base_addr and increment by 1 per accepted write, wrapping modulo 2^ADDRESSSIZE.
REQ-008 Minimum latency SHALL be one cycle from input transfer to wr_en, with sustained throughput of one vector per cycle when wr_ready stays high.
REQ-009 A row counter SHALL count accepted inputs from 0 to TILE_ROWS-1; a write counter SHALL count accepted writes.
REQ-010 start SHALL be ignored when not in IDLE.
REQ-011 in_valid in IDLE SHALL NOT be accepted and SHALL set drop_err; drop_err is cleared only by reset or an accepted start.
REQ-012 busy SHALL be 1 in COLLECT and DRAIN.
REQ-013 Lanes SHALL be written bit-exact, with no truncation, unless REQ-016 applies.

Reset
REQ-014 While rstn = 1, at the next edge:
- state = IDLE, FIFO emptied, counters = 0, address register = 0.
- in_ready = 0, wr_en = 0, wr_data = 0, wr_addr = 0, busy = 0, done = 0, drop_err = 0.
REQ-015 Reset mid-tile SHALL abort the tile without a done pulse, and no write SHALL be issued in the cycle following reset.

Configuration
REQ-016 With RESULT_WRITEBACK_RELU_EN defined, each lane SHALL be clamped to 0 if negative, applied at FIFO push; without it, lanes SHALL pass unchanged and no clamp logic is present.

Structure
REQ-017 A shared package SHALL hold the FSM state enum, the default widths (PARTIAL_SUM_BW, MATRIX_SIZE, ADDRESSSIZE) and the lane-slice helper.
REQ-018 The FIFO SHALL be a separate sub-module, result_skid_fifo, parameterised by data width and fixed at depth 2.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Streaming: start with base_addr = 0x010, 8 back-to-back vectors, wr_ready = 1 -> writes to 0x010..0x017 in order on consecutive cycles, done one cycle after the last input, busy low the next cycle.
- Backpressure: wr_ready = 0 for 5 cycles mid-tile -> in_ready drops after 2 buffered vectors, wr_addr and wr_data stable, no vector lost or duplicated.
- Wrap: base_addr = 0x3FE, 8 vectors -> addresses 0x3FE, 0x3FF, 0x000..0x005.
- ReLU: lane 3 = -5 (0xFFFFB) and lane 0 = 7 -> with RELU_EN: lane 3 = 0, lane 0 = 7; without RELU_EN: lane 3 = 0xFFFFB.
- Protocol errors: in_valid in IDLE -> drop_err = 1 and no wr_en; start during COLLECT -> ignored and address unchanged.
- Reset mid-tile: assert rstn after 4 vectors -> all outputs 0, no done; a fresh tile then completes normally.
